// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: issues word fetches at currentAddress, holds each word for decode, and steers nextAddress.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned redirect targets to the exception vector.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] currentAddress,
  output logic [31:0] nextAddress,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        misalign_fault
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] instr_reg, pc_reg;
  logic        latch;
  logic        misaligned;
  logic [31:0] redirect_addr;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  always_comb begin
    misaligned    = (redirect_target[1:0] != 2'b00);
    redirect_addr = misaligned ? EXC_VECTOR : redirect_target;
  end
`else
  always_comb begin
    misaligned    = 1'b0;
    redirect_addr = redirect_target & ~32'h3;
  end
`endif

  always_comb begin
    state_next  = state_reg;
    latch       = 1'b0;
    imem_req    = 1'b0;
    nextAddress = currentAddress;
    if (!rst) begin
      nextAddress = RESET_VECTOR;
    end else begin
      case (state_reg)
        FETCH: begin
          imem_req = 1'b1;
          // A word returning alongside a redirect belongs to the squashed path.
          if (imem_ready && !redirect) begin
            latch      = 1'b1;
            state_next = HOLD;
          end else if (redirect && !imem_ready) begin
            state_next = DRAIN;
          end
        end
        HOLD: begin
          if (redirect || instr_accept) state_next = FETCH;
          if (instr_accept && !redirect) nextAddress = currentAddress + 32'd4;
        end
        DRAIN: begin
          if (redirect || imem_ready) state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
      if (redirect) nextAddress = redirect_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= FETCH;
      instr_reg <= 32'd0;
      pc_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (latch) begin
        instr_reg <= imem_rdata;
        pc_reg    <= currentAddress;
      end
    end
  end

  assign imem_addr      = currentAddress;
  assign instr          = instr_reg;
  assign instr_pc       = pc_reg;
  assign instr_valid    = (state_reg == HOLD);
  assign misalign_fault = rst & redirect & misaligned;

endmodule
